// File: rtl/cpu_pkg.sv
// Shared control-path types for the basic processor: opcodes, sequencer
// states and default word/opcode widths.
package cpu_pkg;

  localparam int CPU_WORD_W = 8;
  localparam int CPU_OP_W   = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_NOP5  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH0  = 3'd0,
    FETCH1  = 3'd1,
    DECODE  = 3'd2,
    EXEC_RD = 3'd3,
    EXEC_WR = 3'd4,
    BRANCH  = 3'd5,
    HALT    = 3'd6,
    PAUSE   = 3'd7
  } state_t;

  // Unassigned opcodes retire straight out of DECODE.
  function automatic logic is_nop(input opcode_t o);
    return (o == OP_NOP5) || (o == OP_NOP6);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the sysbus strobes.
// Define SINGLE_STEP_EN to add the step input and the PAUSE state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int OP_W   = CPU_OP_W
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            PC_bus,
  output logic            Addr_bus,
  output logic            MDR_bus,
  output logic            ACC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_ACC,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            CS,
  output logic            R_NW,
  output logic            instr_done,
  output logic            halted
);

  if (OP_W != 3 || WORD_W <= OP_W) begin : g_bad_params
    $fatal(1, "cpu_sequencer: unsupported WORD_W/OP_W combination");
  end

  state_t  state;
  opcode_t opc;

  assign opc = opcode_t'(op);

`ifdef SINGLE_STEP_EN
  localparam state_t RETIRE_STATE = PAUSE;

  logic step_d;
  logic step_rise_r;

  // Registered rising-edge detect on step; a held-high step yields one pulse.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      step_d      <= 1'b0;
      step_rise_r <= 1'b0;
    end else begin
      step_d      <= step;
      step_rise_r <= step & ~step_d;
    end
  end
`else
  localparam state_t RETIRE_STATE = FETCH0;
`endif

  // Sequencer state register; memory states hold until mem_ready.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= FETCH0;
    end else begin
      case (state)
        FETCH0:  state <= FETCH1;
        FETCH1:  state <= mem_ready ? DECODE : FETCH1;
        DECODE: begin
          case (opc)
            OP_LOAD, OP_ADD, OP_SUB: state <= EXEC_RD;
            OP_STORE:                state <= EXEC_WR;
            OP_BNE:                  state <= BRANCH;
            OP_HALT:                 state <= HALT;
            default:                 state <= RETIRE_STATE;
          endcase
        end
        EXEC_RD: state <= mem_ready ? RETIRE_STATE : EXEC_RD;
        EXEC_WR: state <= mem_ready ? RETIRE_STATE : EXEC_WR;
        BRANCH:  state <= RETIRE_STATE;
        HALT:    state <= HALT;
`ifdef SINGLE_STEP_EN
        PAUSE:   state <= step_rise_r ? FETCH0 : PAUSE;
`endif
        default: state <= FETCH0;
      endcase
    end
  end

  // Strobe decode; gated by n_reset so every strobe drops the instant reset asserts.
  always_comb begin
    PC_bus     = 1'b0;
    Addr_bus   = 1'b0;
    MDR_bus    = 1'b0;
    ACC_bus    = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    load_IR    = 1'b0;
    load_ACC   = 1'b0;
    load_MAR   = 1'b0;
    load_MDR   = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b1;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (n_reset) begin
      case (state)
        FETCH0: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
        end
        FETCH1: begin
          CS      = 1'b1;
          MDR_bus = 1'b1;
          load_IR = 1'b1;
        end
        DECODE: begin
          Addr_bus   = 1'b1;
          load_MAR   = 1'b1;
          instr_done = is_nop(opc);
        end
        EXEC_RD: begin
          CS         = 1'b1;
          MDR_bus    = 1'b1;
          load_ACC   = mem_ready;
          ALU_add    = mem_ready && (opc == OP_ADD);
          ALU_sub    = mem_ready && (opc == OP_SUB);
          instr_done = mem_ready;
        end
        EXEC_WR: begin
          ACC_bus    = 1'b1;
          load_MDR   = 1'b1;
          CS         = 1'b1;
          R_NW       = 1'b0;
          instr_done = mem_ready;
        end
        BRANCH: begin
          Addr_bus   = ~z_flag;
          load_PC    = ~z_flag;
          instr_done = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end else begin
      R_NW = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer: expected strobe traces
// are built per instruction from the opcode, z_flag and chosen wait counts.
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic       mem_ready;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic PC_bus, Addr_bus, MDR_bus, ACC_bus, load_PC, INC_PC, load_IR, load_ACC;
  logic load_MAR, load_MDR, ALU_add, ALU_sub, CS, R_NW, instr_done, halted;

  always #5 clock = ~clock;

  cpu_sequencer dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .PC_bus(PC_bus), .Addr_bus(Addr_bus), .MDR_bus(MDR_bus), .ACC_bus(ACC_bus),
    .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR), .load_ACC(load_ACC),
    .load_MAR(load_MAR), .load_MDR(load_MDR), .ALU_add(ALU_add), .ALU_sub(ALU_sub),
    .CS(CS), .R_NW(R_NW), .instr_done(instr_done), .halted(halted)
  );

  logic [15:0] obs;
  assign obs = {PC_bus, Addr_bus, MDR_bus, ACC_bus, load_PC, INC_PC, load_IR, load_ACC,
                load_MAR, load_MDR, ALU_add, ALU_sub, CS, R_NW, instr_done, halted};

  localparam logic [15:0] B_PC = 16'h8000, B_ADDR = 16'h4000, B_MDR = 16'h2000, B_ACC = 16'h1000;
  localparam logic [15:0] L_PC = 16'h0800, I_PC = 16'h0400, L_IR = 16'h0200, L_ACC = 16'h0100;
  localparam logic [15:0] L_MAR = 16'h0080, L_MDR = 16'h0040, A_ADD = 16'h0020, A_SUB = 16'h0010;
  localparam logic [15:0] M_CS = 16'h0008, M_RNW = 16'h0004, DONE = 16'h0002, HALTED = 16'h0001;
  localparam logic [15:0] F0_E  = B_PC | L_MAR | I_PC | M_RNW;
  localparam logic [15:0] F1_E  = M_CS | M_RNW | B_MDR | L_IR;
  localparam logic [15:0] DEC_E = B_ADDR | L_MAR | M_RNW;

  typedef struct {
    logic [15:0] exp;
    logic [2:0]  op;
    logic        z;
    logic        mr;
    logic        stp;
  } cyc_t;

  cyc_t tr[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [15:0] e, input logic [2:0] o, input logic zz,
                               input logic m, input logic s);
    cyc_t c;
    c.exp = e; c.op = o; c.z = zz; c.mr = m; c.stp = s;
    tr.push_back(c);
  endfunction

  // Drive one cycle's inputs at a falling edge and let the outputs settle.
  task automatic drive(input cyc_t c);
    op = c.op; z_flag = c.z; mem_ready = c.mr;
`ifdef SINGLE_STEP_EN
    step = c.stp;
`endif
    #2;
  endtask

  // Expected cycle-by-cycle trace of one instruction; op is garbage until IR is loaded.
  task automatic add_instr(input logic [2:0] opv, input logic zv, input int w_f1,
                           input int w_ex, input bit with_pause);
    logic [15:0] fin;
    push(F0_E, rop(), rbit(), rbit(), 1'b0);
    for (int i = 0; i < w_f1; i++) push(F1_E, rop(), rbit(), 1'b0, 1'b0);
    push(F1_E, rop(), rbit(), 1'b1, 1'b0);
    push(DEC_E | ((opv == 3'd5 || opv == 3'd6) ? DONE : 16'h0000), opv, rbit(), rbit(), 1'b0);
    case (opv)
      3'd0, 3'd2, 3'd3: begin
        for (int i = 0; i < w_ex; i++) push(M_CS | M_RNW | B_MDR, opv, rbit(), 1'b0, 1'b0);
        fin = M_CS | M_RNW | B_MDR | L_ACC | DONE;
        if (opv == 3'd2) fin = fin | A_ADD;
        if (opv == 3'd3) fin = fin | A_SUB;
        push(fin, opv, rbit(), 1'b1, 1'b0);
      end
      3'd1: begin
        for (int i = 0; i < w_ex; i++) push(B_ACC | L_MDR | M_CS, opv, rbit(), 1'b0, 1'b0);
        push(B_ACC | L_MDR | M_CS | DONE, opv, rbit(), 1'b1, 1'b0);
      end
      3'd4: push(M_RNW | DONE | (zv ? 16'h0000 : (B_ADDR | L_PC)), opv, zv, rbit(), 1'b0);
      default: ;
    endcase
    if (with_pause && opv != 3'd7) begin
`ifdef SINGLE_STEP_EN
      push(M_RNW, rop(), rbit(), rbit(), 1'b1);
      push(M_RNW, rop(), rbit(), rbit(), 1'b0);
`endif
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      op = rop(); z_flag = rbit(); mem_ready = rbit();
      #2;
      n_cmp++;
      if (obs !== M_RNW) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d got=%h want=%h", i, obs, M_RNW);
      end
    end
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_load();
    cyc_t c;
    int k = 0;
    add_instr(3'd0, rbit(), 0, 0, 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL load cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

  task automatic test_store_wait();
    cyc_t c;
    int k = 0;
    add_instr(3'd1, rbit(), 1, 3, 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL store_wait cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    int k = 0;
    add_instr(3'd4, 1'b0, 0, 0, 1'b1);
    add_instr(3'd4, 1'b1, 0, 0, 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL branch cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

  task automatic test_alu_nop();
    cyc_t c;
    int k = 0;
    add_instr(3'd2, rbit(), 0, $urandom_range(0, 2), 1'b1);
    add_instr(3'd3, rbit(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    add_instr(3'd5, rbit(), 0, 0, 1'b1);
    add_instr(3'd6, rbit(), 1, 0, 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL alu_nop cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int k = 0;
    for (int i = 0; i < 15; i++)
      add_instr(3'($urandom_range(0, 6)), rbit(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL back_to_back cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc_t c;
    add_instr(3'd1, 1'b0, 0, 6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL mid_wait cyc%0d got=%h want=%h", k, obs, c.exp); end
      @(negedge clock);
    end
    tr.delete();
    mem_ready = 1'b0;
    #3 n_reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== M_RNW) begin n_fail++; $display("FAIL mid_wait_async_clear got=%h want=%h", obs, M_RNW); end
    @(negedge clock);
    mem_ready = 1'b1;
    #2;
    n_cmp++;
    if (obs !== M_RNW) begin n_fail++; $display("FAIL mid_wait_held_reset got=%h want=%h", obs, M_RNW); end
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_halt();
    cyc_t c;
    int k = 0;
    add_instr(3'd7, rbit(), 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) push(HALTED | M_RNW, rop(), rbit(), rbit(), rbit());
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL halt cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
    #3 n_reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== M_RNW) begin n_fail++; $display("FAIL halt_async_clear got=%h want=%h", obs, M_RNW); end
    @(negedge clock);
    n_reset = 1'b1;
    k = 0;
    add_instr(3'd0, rbit(), 0, 1, 1'b1);
    while (tr.size() > 0) begin
      c = tr.pop_front(); drive(c); n_cmp++;
      if (obs !== c.exp) begin n_fail++; $display("FAIL halt_restart cyc%0d got=%h want=%h", k, obs, c.exp); end
      k++; @(negedge clock);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int  dones = 0;
    int  waited = 0;
    bit  resumed = 1'b0;
    step = 1'b1;
    n_reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = (i < 4) ? 3'd0 : rop(); z_flag = rbit(); mem_ready = 1'b1;
      #2;
      if (instr_done) dones++;
      if (i >= 4) begin
        n_cmp++;
        if (obs !== M_RNW) begin n_fail++; $display("FAIL step_pause cyc%0d got=%h want=%h", i, obs, M_RNW); end
      end
      @(negedge clock);
    end
    n_cmp++;
    if (dones != 1) begin n_fail++; $display("FAIL step_one_instr got=%0d want=1", dones); end
    step = 1'b0;
    @(negedge clock);
    step = 1'b1;
    while (!resumed && waited < 5) begin
      @(negedge clock);
      #2;
      waited++;
      if (obs === F0_E) resumed = 1'b1;
    end
    n_cmp++;
    if (!resumed) begin n_fail++; $display("FAIL step_resume got=%h want=%h", obs, F0_E); end
    step = 1'b0;
  endtask
`endif

  initial begin
    n_reset = 1'b0; op = 3'd0; z_flag = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_load();
    test_store_wait();
    test_branch();
    test_alu_nop();
    test_back_to_back();
    test_reset_mid_wait();
    test_halt();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
